// File: rtl/pixel_readout.sv
// pixel_readout: ADC ramp generator, 2x2 row capture and pixel stream
// sitting between the readout control FSM and the frame sink.
module pixel_readout #(
    parameter int DATA_W = 8,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ADC,
    input  logic              NRE_1,
    input  logic              NRE_2,
    input  logic [DATA_W-1:0] col_0,
    input  logic [DATA_W-1:0] col_1,
    output logic [DATA_W-1:0] ramp,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frame_overrun,
    output logic              row_conflict
);

    // Low-counter saturates at SETTLE; the sample fires on the
    // edge that moves it from SETTLE-1 to SETTLE, so only once.
    localparam logic [2:0] CNT_TOP = 3'(SETTLE);
    localparam logic [2:0] CNT_HIT = 3'(SETTLE - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_q;
    logic                   adc_q;
    logic [DATA_W-1:0]      ramp_q, ramp_d;
    logic [2:0]             cnt1_q, cnt1_d;
    logic [2:0]             cnt2_q, cnt2_d;
    logic                   got1_q, got1_d;
    logic                   got2_q, got2_d;
    logic [DATA_W-1:0]      r1c0_q, r1c1_q;
    logic [DATA_W-1:0]      r2c0_q, r2c1_q;
    logic [3:0][DATA_W-1:0] pix_q;
    logic [1:0]             idx_q;
    logic [DATA_W-1:0]      out_data_q;
    logic                   out_valid_q;
    logic                   overrun_q;
    logic                   conflict_q;

    logic rise;
    logic conflict;
    logic samp1;
    logic samp2;
    logic complete;

    // Decode ADC rise, row conflict, per-row sample points, frame done
    always_comb begin
        rise     = ADC & ~adc_q;
        conflict = ~NRE_1 & ~NRE_2;
        samp1    = ~conflict & ~NRE_1 & (cnt1_q == CNT_HIT);
        samp2    = ~conflict & ~NRE_2 & (cnt2_q == CNT_HIT);
        complete = got1_q & got2_q;
    end

    // Next state of low-counters, row flags and ramp code
    always_comb begin
        cnt1_d = cnt1_q;
        if (NRE_1 | conflict) begin
            cnt1_d = '0;
        end else if (cnt1_q != CNT_TOP) begin
            cnt1_d = cnt1_q + 3'd1;
        end

        cnt2_d = cnt2_q;
        if (NRE_2 | conflict) begin
            cnt2_d = '0;
        end else if (cnt2_q != CNT_TOP) begin
            cnt2_d = cnt2_q + 3'd1;
        end

        // A new capture on the same edge still counts for the next frame
        got1_d = got1_q;
        got2_d = got2_q;
        if (rise | complete) begin
            got1_d = 1'b0;
            got2_d = 1'b0;
        end
        if (samp1) got1_d = 1'b1;
        if (samp2) got2_d = 1'b1;

        ramp_d = ramp_q;
        if (rise) begin
            ramp_d = '0;
        end else if (ADC && ramp_q != '1) begin
            ramp_d = ramp_q + DATA_W'(1);
        end
    end

    // Ramp, row capture state and shadow column registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_q      <= 1'b0;
            ramp_q     <= '0;
            cnt1_q     <= '0;
            cnt2_q     <= '0;
            got1_q     <= 1'b0;
            got2_q     <= 1'b0;
            r1c0_q     <= '0;
            r1c1_q     <= '0;
            r2c0_q     <= '0;
            r2c1_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            adc_q      <= ADC;
            ramp_q     <= ramp_d;
            cnt1_q     <= cnt1_d;
            cnt2_q     <= cnt2_d;
            got1_q     <= got1_d;
            got2_q     <= got2_d;
            conflict_q <= conflict;
            if (samp1) begin
                r1c0_q <= col_0;
                r1c1_q <= col_1;
            end
            if (samp2) begin
                r2c0_q <= col_0;
                r2c1_q <= col_1;
            end
        end
    end

    // Output FSM: load a finished frame when idle, stream four words
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pix_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= complete & (state_q != IDLE);
            unique case (state_q)
                IDLE: begin
                    if (complete) begin
                        pix_q       <= {r2c1_q, r2c0_q, r1c1_q, r1c0_q};
                        idx_q       <= 2'd0;
                        out_data_q  <= r1c0_q;
                        out_valid_q <= 1'b1;
                        state_q     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            idx_q      <= idx_q + 2'd1;
                            out_data_q <= pix_q[idx_q + 2'd1];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ramp          = ramp_q;
    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign frame_overrun = overrun_q;
    assign row_conflict  = conflict_q;

endmodule

// File: tb/tb_pixel_readout.sv
// tb_pixel_readout: directed and random stimulus on two instances
// (SETTLE=1 and SETTLE=3) checked against a frame-level model.
module tb_pixel_readout;
    localparam int W = 8;
    localparam int ST[2] = '{1, 3};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ADC = 1'b0;
    logic         NRE_1 = 1'b1;
    logic         NRE_2 = 1'b1;
    logic         out_ready = 1'b0;
    logic [W-1:0] col_0 = '0;
    logic [W-1:0] col_1 = '0;

    logic [W-1:0] ramp_o[2];
    logic [W-1:0] data_o[2];
    logic         valid_o[2];
    logic         ovr_o[2];
    logic         conf_o[2];

    int nvec = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    pixel_readout #(.DATA_W(W), .SETTLE(1)) u_s1 (
        .clk(clk), .reset(reset), .ADC(ADC),
        .NRE_1(NRE_1), .NRE_2(NRE_2),
        .col_0(col_0), .col_1(col_1),
        .ramp(ramp_o[0]), .out_data(data_o[0]),
        .out_valid(valid_o[0]), .out_ready(out_ready),
        .frame_overrun(ovr_o[0]), .row_conflict(conf_o[0])
    );

    pixel_readout #(.DATA_W(W), .SETTLE(3)) u_s3 (
        .clk(clk), .reset(reset), .ADC(ADC),
        .NRE_1(NRE_1), .NRE_2(NRE_2),
        .col_0(col_0), .col_1(col_1),
        .ramp(ramp_o[1]), .out_data(data_o[1]),
        .out_valid(valid_o[1]), .out_ready(out_ready),
        .frame_overrun(ovr_o[1]), .row_conflict(conf_o[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Rows: run length of the current low period; a capture happens
    // when the run length first equals SETTLE. Output: pending words.
    int m_ramp;
    bit m_adc;
    bit m_conf;
    int low1[2], low2[2];
    bit g1[2], g2[2];
    int sh[2][4];
    int m_buf[2][4];
    int m_left[2];
    bit m_ovr[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_ramp = 0; m_adc = 0; m_conf = 0;
            for (int u = 0; u < 2; u++) begin
                low1[u] = 0; low2[u] = 0; g1[u] = 0; g2[u] = 0;
                m_left[u] = 0; m_ovr[u] = 0;
                for (int k = 0; k < 4; k++) sh[u][k] = 0;
            end
        end else begin
            bit rise, conf;
            rise = ADC && !m_adc;
            conf = !NRE_1 && !NRE_2;
            if (rise) m_ramp = 0;
            else if (ADC && m_ramp < 255) m_ramp = m_ramp + 1;
            for (int u = 0; u < 2; u++) begin
                bit s1, s2, cpl, busy;
                s1 = 0; s2 = 0;
                cpl = g1[u] && g2[u];
                busy = m_left[u] != 0;
                if (conf || NRE_1) low1[u] = 0;
                else begin low1[u]++; s1 = (low1[u] == ST[u]); end
                if (conf || NRE_2) low2[u] = 0;
                else begin low2[u]++; s2 = (low2[u] == ST[u]); end
                m_ovr[u] = cpl && busy;
                if (busy && out_ready) m_left[u]--;
                if (cpl && !busy) begin
                    m_buf[u] = sh[u];
                    m_left[u] = 4;
                end
                if (s1) begin sh[u][0] = col_0; sh[u][1] = col_1; end
                if (s2) begin sh[u][2] = col_0; sh[u][3] = col_1; end
                if (rise || cpl) begin g1[u] = 0; g2[u] = 0; end
                if (s1) g1[u] = 1;
                if (s2) g2[u] = 1;
            end
            m_conf = conf;
            m_adc = ADC;
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("ramp%0d", u), ramp_o[u], m_ramp);
            chk($sformatf("valid%0d", u), valid_o[u], m_left[u] != 0);
            if (m_left[u] != 0)
                chk($sformatf("data%0d", u), data_o[u],
                    m_buf[u][4 - m_left[u]]);
            chk($sformatf("ovr%0d", u), ovr_o[u], m_ovr[u]);
            chk($sformatf("conf%0d", u), conf_o[u], m_conf);
        end
    end

    // Word log and overrun count from the SETTLE=1 instance
    logic [W-1:0] wlog[$];
    int ovr_cnt = 0;
    always @(negedge clk) begin
        if (!reset && valid_o[0] && out_ready) wlog.push_back(data_o[0]);
        if (ovr_o[0]) ovr_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_words(input string nm, input int a, input int b,
                             input int c, input int d);
        int e[4];
        e = '{a, b, c, d};
        chk({nm, "_n"}, wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(nm, (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF, e[i]);
        wlog.delete();
    endtask

    task automatic row(input int r, input int c0, input int c1,
                       input int n);
        col_0 = W'(c0);
        col_1 = W'(c1);
        if (r == 1) NRE_1 = 1'b0; else NRE_2 = 1'b0;
        step(n);
        NRE_1 = 1'b1;
        NRE_2 = 1'b1;
    endtask

    initial begin
        step(2);
        chk("rst_data", data_o[0], 0);
        chk("rst_ramp", ramp_o[0], 0);
        chk("rst_valid", valid_o[1], 0);
        reset = 1'b0;
        step(1);

        // Ramp: 300 cycles high, saturate, hold, reload on next rise
        ADC = 1'b1;
        step(300);
        chk("ramp_sat", ramp_o[0], 255);
        ADC = 1'b0;
        step(5);
        chk("ramp_hold", ramp_o[0], 255);
        ADC = 1'b1;
        step(1);
        chk("ramp_reload", ramp_o[0], 0);
        step(3);
        chk("ramp_k3", ramp_o[0], 3);
        ADC = 1'b0;
        step(2);

        // Basic frame, ready held high
        out_ready = 1'b1;
        wlog.delete();
        row(1, 'h11, 'h22, 3);
        row(2, 'h33, 'h44, 3);
        step(8);
        chk_words("frame1", 'h11, 'h22, 'h33, 'h44);

        // Long low period with moving columns: one sample only
        col_0 = 8'hAA; col_1 = 8'hBB; NRE_1 = 1'b0;
        step(3);
        for (int i = 0; i < 5; i++) begin
            col_0 = W'($urandom); col_1 = W'($urandom);
            step(1);
        end
        NRE_1 = 1'b1;
        row(2, 'hCC, 'hDD, 3);
        step(8);
        chk_words("noresamp", 'hAA, 'hBB, 'hCC, 'hDD);

        // Backpressure with a second frame arriving while busy
        out_ready = 1'b0;
        ovr_cnt = 0;
        row(1, 'h11, 'h22, 3);
        row(2, 'h33, 'h44, 3);
        step(2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", valid_o[0], 1);
            chk("bp_hold", data_o[0], 'h11);
            step(1);
        end
        row(1, 'h55, 'h66, 3);
        row(2, 'h77, 'h88, 3);
        step(2);
        chk("ovr_once", ovr_cnt, 1);
        out_ready = 1'b1;
        step(8);
        chk_words("bp", 'h11, 'h22, 'h33, 'h44);

        // Conflict, then reversed row order
        col_0 = 8'h99; col_1 = 8'h98;
        NRE_1 = 1'b0; NRE_2 = 1'b0;
        step(1);
        chk("conf_a", conf_o[0], 1);
        step(1);
        chk("conf_b", conf_o[0], 1);
        NRE_1 = 1'b1; NRE_2 = 1'b1;
        step(3);
        chk("conf_nocap", valid_o[0], 0);
        row(2, 'h33, 'h44, 3);
        row(1, 'h11, 'h22, 3);
        step(8);
        chk_words("reverse", 'h11, 'h22, 'h33, 'h44);

        // SETTLE=3: short low period captures nothing
        out_ready = 1'b0;
        row(1, 'h51, 'h52, 2);
        step(1);
        row(2, 'h53, 'h54, 3);
        step(3);
        chk("s3_short", valid_o[1], 0);
        col_0 = 8'h61; col_1 = 8'h62; NRE_1 = 1'b0;
        step(2);
        col_0 = 8'h71; col_1 = 8'h72;
        step(1);
        NRE_1 = 1'b1;
        step(2);
        chk("s3_valid", valid_o[1], 1);
        chk("s3_third", data_o[1], 'h71);
        out_ready = 1'b1;
        step(12);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) ADC = ~ADC;
            if (NRE_1) NRE_1 = ($urandom_range(5) != 0);
            else NRE_1 = ($urandom_range(3) == 0);
            if (NRE_2) NRE_2 = ($urandom_range(5) != 0);
            else NRE_2 = ($urandom_range(3) == 0);
            col_0 = W'($urandom);
            col_1 = W'($urandom);
            out_ready = ($urandom_range(2) != 0);
            step(1);
        end
        ADC = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1; out_ready = 1'b1;
        step(12);

        // Reset in the middle of a frame, word 2 pending
        out_ready = 1'b0;
        row(1, 'h11, 'h22, 3);
        row(2, 'h33, 'h44, 3);
        step(3);
        out_ready = 1'b1;
        step(2);
        chk("pre_rst", data_o[0], 'h33);
        reset = 1'b1;
        #1;
        chk("rst_valid", valid_o[0], 0);
        chk("rst_ramp2", ramp_o[0], 0);
        chk("rst_ovr", ovr_o[0], 0);
        step(1);
        reset = 1'b0;
        wlog.delete();
        row(1, 'h11, 'h22, 3);
        row(2, 'h33, 'h44, 3);
        step(8);
        chk_words("after_rst", 'h11, 'h22, 'h33, 'h44);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
